// File: rtl/mha_pkg.sv
// mha_pkg: shared state type, default sizes and saturating subtract for the MHA softmax path
package mha_pkg;
    localparam int D_W = 16;
    localparam int NUM = 16;

    typedef enum logic [2:0] {S_LOAD, S_NORM, S_RUN, S_GAP, S_DRAIN} smd_state_t;

    // a - b at D_W+1 bits, clamped to [-2^(D_W-1), 0]
    function automatic logic signed [D_W-1:0] sat_sub(input logic signed [D_W-1:0] a,
                                                       input logic signed [D_W-1:0] b);
        logic signed [D_W:0] d;
        d = (D_W+1)'(a) - (D_W+1)'(b);
        if (!d[D_W]) return '0;
        if (!d[D_W-1]) return {1'b1, {(D_W-1){1'b0}}};
        return d[D_W-1:0];
    endfunction
endpackage

// File: rtl/softmax_row_driver_row_max_sub.sv
// row_max_sub: signed running max of a loading row and the row minus that max, saturated
module row_max_sub #(
    parameter int D_W = mha_pkg::D_W,
    parameter int NUM = mha_pkg::NUM
) (
    input  logic                      I_CLK,
    input  logic                      I_RST_N,
    input  logic                      i_en,
    input  logic                      i_first,
    input  logic signed [D_W-1:0]     i_data,
    input  logic [0:NUM-1][D_W-1:0]   i_row,
    output logic [0:NUM-1][D_W-1:0]   o_row
);
    import mha_pkg::*;

    logic signed [D_W-1:0] max_q, max_d;

    always_comb begin
        max_d = (i_en && (i_first || i_data > max_q)) ? i_data : max_q;
        for (int i = 0; i < NUM; i++) o_row[i] = sat_sub($signed(i_row[i]), max_q);
    end

    always_ff @(posedge I_CLK or negedge I_RST_N)
        if (!I_RST_N) max_q <= '0;
        else max_q <= max_d;
endmodule

// File: rtl/softmax_row_driver.sv
// softmax_row_driver: loads a score row, optionally max-normalises it, runs the softmax unit and streams the result
module softmax_row_driver #(
    parameter int D_W     = mha_pkg::D_W,
    parameter int NUM     = mha_pkg::NUM,
    parameter int SUB_MAX = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                     I_CLK,
    input  logic                     I_RST_N,
    input  logic                     I_IN_VLD,
    output logic                     O_IN_RDY,
    input  logic [D_W-1:0]           I_IN_DATA,
    output logic                     O_SM_START,
    output logic [0:NUM-1][D_W-1:0]  O_SM_DATA,
    input  logic                     I_SM_VLD,
    input  logic [0:NUM-1][D_W-1:0]  I_SM_DATA,
    output logic                     O_OUT_VLD,
    input  logic                     I_OUT_RDY,
    output logic [D_W-1:0]           O_OUT_DATA,
    output logic                     O_OUT_LAST,
    output logic                     O_ERR,
    output logic [15:0]              O_ROW_CNT
);
    import mha_pkg::*;

    localparam int CW = $clog2(NUM);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM - 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

    smd_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wd_q, wd_d;
    logic to_q, to_d;
    logic [15:0] row_cnt_q, row_cnt_d;
    logic [0:NUM-1][D_W-1:0] in_buf_q, in_buf_d, out_buf_q, out_buf_d, norm_row;
    logic sm_start_q, sm_start_d, out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [D_W-1:0] out_data_q, out_data_d;

    row_max_sub #(.D_W(D_W), .NUM(NUM)) u_max (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .i_en    (state_q == S_LOAD && I_IN_VLD),
        .i_first (cnt_q == '0),
        .i_data  (I_IN_DATA),
        .i_row   (in_buf_q),
        .o_row   (norm_row)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        to_d      = to_q;
        row_cnt_d = row_cnt_q;
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;
        case (state_q)
            S_LOAD: if (I_IN_VLD) begin
                in_buf_d[cnt_q] = I_IN_DATA;
                cnt_d   = cnt_q == LAST_IDX ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == LAST_IDX ? S_NORM : S_LOAD;
            end
            S_NORM: begin
                in_buf_d = SUB_MAX != 0 ? norm_row : in_buf_q;
                state_d  = S_RUN;
            end
            S_RUN: begin
                to_d    = !I_SM_VLD;
                wd_d    = (I_SM_VLD || wd_q == WD_MAX) ? '0 : wd_q + 1'b1;
                state_d = (I_SM_VLD || wd_q == WD_MAX) ? S_GAP : S_RUN;
                if (I_SM_VLD) out_buf_d = I_SM_DATA;
            end
            // watchdog doubles as the two-cycle gap counter
            S_GAP: begin
                wd_d    = wd_q == WW'(1) ? '0 : wd_q + 1'b1;
                state_d = wd_q == WW'(1) ? (to_q ? S_LOAD : S_DRAIN) : S_GAP;
            end
            S_DRAIN: if (I_OUT_RDY) begin
                cnt_d     = cnt_q == LAST_IDX ? '0 : cnt_q + 1'b1;
                row_cnt_d = cnt_q == LAST_IDX ? row_cnt_q + 16'd1 : row_cnt_q;
                state_d   = cnt_q == LAST_IDX ? S_LOAD : S_DRAIN;
            end
            default: state_d = S_LOAD;
        endcase
        sm_start_d = state_d == S_RUN;
        out_vld_d  = state_d == S_DRAIN;
        out_data_d = state_d == S_DRAIN ? out_buf_d[cnt_d] : '0;
        out_last_d = state_d == S_DRAIN && cnt_d == LAST_IDX;
    end

    always_ff @(posedge I_CLK or negedge I_RST_N)
        if (!I_RST_N) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            wd_q       <= '0;
            to_q       <= 1'b0;
            row_cnt_q  <= '0;
            in_buf_q   <= '0;
            out_buf_q  <= '0;
            sm_start_q <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            to_q       <= to_d;
            row_cnt_q  <= row_cnt_d;
            in_buf_q   <= in_buf_d;
            out_buf_q  <= out_buf_d;
            sm_start_q <= sm_start_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end

    assign O_IN_RDY   = state_q == S_LOAD;
    assign O_SM_START = sm_start_q;
    assign O_SM_DATA  = in_buf_q;
    assign O_OUT_VLD  = out_vld_q;
    assign O_OUT_DATA = out_data_q;
    assign O_OUT_LAST = out_last_q;
    assign O_ERR      = state_q == S_RUN && wd_q == WD_MAX && !I_SM_VLD;
    assign O_ROW_CNT  = row_cnt_q;
endmodule

// File: tb/tb_softmax_row_driver.sv
// tb_softmax_row_driver: directed and randomized rows against a behavioural softmax model
module tb_softmax_row_driver;
    localparam int D_W = 16;
    localparam int NUM = 16;
    localparam int TMO = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_vld = 1'b0, sm_vld = 1'b0, out_rdy = 1'b0;
    logic [D_W-1:0] in_data = '0;
    logic [0:NUM-1][D_W-1:0] sm_data_i = '0;
    logic [0:NUM-1][D_W-1:0] sm_data_o;
    logic in_rdy, sm_start, out_vld, out_last, err;
    logic [D_W-1:0] out_data;
    logic [15:0] row_cnt;

    int checks = 0, failures = 0;
    int mode = 1;     // 0: unit never answers, 1: constant 0x0010, 2: data-dependent result
    int lat = 3, mcnt = 0, n_vld = 0, exp_rows = 0;

    softmax_row_driver #(.D_W(D_W), .NUM(NUM), .SUB_MAX(1), .TIMEOUT(TMO)) dut (
        .I_CLK(clk), .I_RST_N(rst_n), .I_IN_VLD(in_vld), .O_IN_RDY(in_rdy), .I_IN_DATA(in_data),
        .O_SM_START(sm_start), .O_SM_DATA(sm_data_o), .I_SM_VLD(sm_vld), .I_SM_DATA(sm_data_i),
        .O_OUT_VLD(out_vld), .I_OUT_RDY(out_rdy), .O_OUT_DATA(out_data), .O_OUT_LAST(out_last),
        .O_ERR(err), .O_ROW_CNT(row_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [D_W-1:0] sm_fn(input int i, input logic [D_W-1:0] v);
        return v ^ (16'h1357 + 16'(i * 257));
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // softmax unit: level-held start, one-cycle valid, restarts if start is still high when valid is taken
    initial forever begin
        @(negedge clk);
        if (!rst_n || !sm_start || mode == 0) begin
            mcnt = 0;
            sm_vld = 1'b0;
        end else if (sm_vld) begin
            sm_vld = 1'b0;
            mcnt = 1;
        end else if (mcnt >= lat) begin
            sm_vld = 1'b1;
            n_vld++;
            for (int i = 0; i < NUM; i++) sm_data_i[i] = mode == 1 ? 16'h0010 : sm_fn(i, sm_data_o[i]);
            mcnt = 0;
        end else mcnt++;
    end

    task automatic chk_reset_vals();
        chk("rst_in_rdy", 256'(in_rdy), 256'(1));
        chk("rst_start", 256'(sm_start), 256'(0));
        chk("rst_sm_data", 256'(sm_data_o), 256'(0));
        chk("rst_out_vld", 256'(out_vld), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_out_last", 256'(out_last), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_row_cnt", 256'(row_cnt), 256'(0));
    endtask

    task automatic load_row(input logic [D_W-1:0] row [NUM]);
        int i = 0, guard = 0;
        while (i < NUM && guard < 200) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(0, 3) == 0) in_vld = 1'b0;
            else begin
                in_vld = 1'b1;
                in_data = row[i];
                if (in_rdy) i++;
            end
        end
        @(negedge clk);
        in_vld = 1'b0;
        chk("load_done", 256'(i), 256'(NUM));
    endtask

    task automatic wait_start();
        int g = 0;
        while (!sm_start && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("start_seen", 256'(sm_start), 256'(1));
    endtask

    task automatic run_row(input logic [D_W-1:0] row [NUM], input int rdy_mode);
        logic [0:NUM-1][D_W-1:0] nrow;
        logic [D_W-1:0] eo [NUM];
        logic [D_W:0] held = '0;
        logic seen = 1'b0, stalled = 1'b0;
        int mx, v, v0, k = 0, gap = 0, cyc = 0;
        mx = int'($signed(row[0]));
        for (int i = 1; i < NUM; i++) if (int'($signed(row[i])) > mx) mx = int'($signed(row[i]));
        for (int i = 0; i < NUM; i++) begin
            v = int'($signed(row[i])) - mx;
            if (v < -32768) v = -32768;
            nrow[i] = 16'(v);
            eo[i] = mode == 1 ? 16'h0010 : sm_fn(i, 16'(v));
        end
        v0 = n_vld;
        out_rdy = 1'b0;
        load_row(row);
        wait_start();
        chk("sm_data", 256'(sm_data_o), 256'(nrow));
        while (k < NUM && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!out_vld) begin
                if (!sm_start) gap++;
                continue;
            end
            if (!seen) begin
                seen = 1'b1;
                chk("gap_len", 256'(gap), 256'(2));
            end
            if (stalled) chk("stall_hold", 256'({out_last, out_data}), 256'(held));
            out_rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~out_rdy : 1'($urandom_range(0, 1));
            if (out_rdy) begin
                chk($sformatf("out_data[%0d]", k), 256'(out_data), 256'(eo[k]));
                chk($sformatf("out_last[%0d]", k), 256'(out_last), 256'(k == NUM - 1));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = {out_last, out_data};
            end
        end
        chk("all_out", 256'(k), 256'(NUM));
        @(negedge clk);
        out_rdy = 1'b0;
        exp_rows++;
        chk("row_cnt", 256'(row_cnt), 256'(exp_rows));
        chk("one_result", 256'(n_vld - v0), 256'(1));
        chk("back_to_load", 256'(in_rdy), 256'(1));
        chk("no_vld_after", 256'(out_vld), 256'(0));
    endtask

    task automatic rand_row(output logic [D_W-1:0] row [NUM]);
        for (int i = 0; i < NUM; i++)
            case ($urandom_range(0, 5))
                0: row[i] = 16'h7FFF;
                1: row[i] = 16'h8000;
                default: row[i] = 16'($urandom);
            endcase
    endtask

    initial begin
        logic [D_W-1:0] row [NUM];
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // basic: flat row normalises to zeros, constant result
        mode = 1;
        for (int i = 0; i < NUM; i++) row[i] = 16'h0100;
        run_row(row, 0);

        // max subtraction with saturation at the negative limit
        mode = 2;
        for (int i = 0; i < NUM; i++) row[i] = 16'h0000;
        row[0] = 16'h7FFF;
        row[1] = 16'h8000;
        run_row(row, 0);

        // backpressure toggling every cycle
        rand_row(row);
        run_row(row, 1);

        // random rows, random latency and random ready
        for (int r = 0; r < 4; r++) begin
            lat = $urandom_range(1, 5);
            rand_row(row);
            run_row(row, 2);
        end

        // timeout: unit never answers
        mode = 0;
        rand_row(row);
        load_row(row);
        wait_start();
        for (int c = 1; c <= TMO; c++) begin
            chk($sformatf("to_err[%0d]", c), 256'(err), 256'(c == TMO));
            chk($sformatf("to_start[%0d]", c), 256'(sm_start), 256'(1));
            if (c < TMO) @(negedge clk);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("to_no_vld", 256'(out_vld), 256'(0));
            chk("to_err_low", 256'(err), 256'(0));
        end
        chk("to_in_rdy", 256'(in_rdy), 256'(1));
        chk("to_row_cnt", 256'(row_cnt), 256'(exp_rows));

        // clean row after a timeout
        mode = 2;
        lat = 2;
        rand_row(row);
        run_row(row, 2);

        // reset in the middle of S_RUN
        mode = 0;
        rand_row(row);
        load_row(row);
        wait_start();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        exp_rows = 0;
        mode = 2;
        lat = 3;
        rand_row(row);
        run_row(row, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
